// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and address geometry for the read/write engines.
package sdram_pkg;

  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned BANK_W = 2;

  // {CS_n, RAS_n, CAS_n, WE_n}
  typedef enum logic [3:0] {
    CMD_NOP    = 4'b0111,
    CMD_ACTIVE = 4'b0011,
    CMD_READ   = 4'b0101,
    CMD_WRITE  = 4'b0100,
    CMD_PRECH  = 4'b0010
  } sdram_cmd_t;

  localparam logic [ROW_W-1:0] A10_ALL = 13'h0400;

endpackage

// File: rtl/sdram_trig_sync.sv
// Two-flop synchroniser plus edge register; rise is high for one cycle per rising edge of trig.
module sdram_trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic rise
);

  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], trig};
  end

  assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/sdram_write.sv
// SDRAM write-path engine: arbiter request, ACTIVE, BURSTS_PER_TRIG WRITE bursts, PRECHARGE.
// The {bank,row,col} address advances linearly across triggers and yields to refresh between bursts.
module sdram_write
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_LEN       = 4,
  parameter int unsigned BURSTS_PER_TRIG = 2,
  parameter int unsigned T_RCD           = 2,
  parameter int unsigned T_WR            = 2,
  parameter int unsigned T_RP            = 2,
  parameter int unsigned DQ_W            = 16
) (
  input  logic              sysclk_100M,
  input  logic              rst,
  output logic [3:0]        cmd_reg,
  output logic [ROW_W-1:0]  sdram_addr,
  output logic [BANK_W-1:0] sdram_bank_addr,
  output logic [DQ_W-1:0]   sdram_dq,
  output logic              sdram_dq_oe,
  input  logic              refresh_req,
  output logic              arbit_write_req,
  input  logic              arbit_write_ack,
  output logic              arbit_write_end,
  input  logic              write_trig,
  output logic              wr_data_req,
  input  logic [DQ_W-1:0]   wr_data,
  output logic              write_end
);

  localparam int unsigned W_END = BURST_LEN + T_WR - 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BR_W  = BANK_W + ROW_W;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_WRITE, S_PRECH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic [BR_W-1:0]  bank_row;
  logic [COL_W-1:0] col;
  logic             row_end;
  logic             trig_rise;
  logic             done;

  sdram_trig_sync u_trig_sync (
    .clk  (sysclk_100M),
    .rst  (rst),
    .trig (write_trig),
    .rise (trig_rise)
  );

  always_comb begin
    wr_data_req = (state == S_WRITE) && (cnt < CNT_W'(BURST_LEN));
    done        = (burst_cnt == CNT_W'(BURSTS_PER_TRIG));
  end

  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      burst_cnt       <= '0;
      bank_row        <= '0;
      col             <= '0;
      row_end         <= 1'b0;
      cmd_reg         <= CMD_NOP;
      sdram_addr      <= A10_ALL;
      sdram_bank_addr <= '0;
      sdram_dq        <= '0;
      sdram_dq_oe     <= 1'b0;
      arbit_write_req <= 1'b0;
      arbit_write_end <= 1'b0;
      write_end       <= 1'b0;
    end else begin
      cmd_reg         <= CMD_NOP;
      sdram_addr      <= A10_ALL;
      sdram_dq_oe     <= 1'b0;
      arbit_write_end <= 1'b0;
      write_end       <= 1'b0;
      cnt             <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (trig_rise) begin
            state           <= S_REQ;
            arbit_write_req <= 1'b1;
          end
        end
        S_REQ: begin
          cnt <= '0;
          if (arbit_write_ack) begin
            state           <= S_ACT;
            arbit_write_req <= 1'b0;
            row_end         <= 1'b0;
          end
        end
        S_ACT: begin
          if (cnt == '0) begin
            cmd_reg                       <= CMD_ACTIVE;
            {sdram_bank_addr, sdram_addr} <= bank_row;
          end
          if (cnt == CNT_W'(T_RCD - 1)) begin
            state <= S_WRITE;
            cnt   <= '0;
          end
        end
        S_WRITE: begin
          if (wr_data_req) begin
            sdram_dq    <= wr_data;
            sdram_dq_oe <= 1'b1;
          end
          if (cnt == '0) begin
            cmd_reg         <= CMD_WRITE;
            sdram_addr      <= {{(ROW_W-COL_W){1'b0}}, col};
            sdram_bank_addr <= bank_row[BR_W-1 -: BANK_W];
          end
          // Column/burst bookkeeping lands before W_END, so the exit test sees the updated values.
          if (cnt == CNT_W'(BURST_LEN - 1)) begin
            col       <= col + COL_W'(BURST_LEN);
            burst_cnt <= burst_cnt + 1'b1;
            if (col == COL_W'((1 << COL_W) - BURST_LEN)) begin
              bank_row <= bank_row + 1'b1;
              row_end  <= 1'b1;
            end
          end
          if (cnt == CNT_W'(W_END)) begin
            cnt   <= '0;
            state <= (done || refresh_req || row_end) ? S_PRECH : S_WRITE;
          end
        end
        S_PRECH: begin
          if (cnt == '0) cmd_reg <= CMD_PRECH;
          if (cnt == CNT_W'(T_RP - 1)) begin
            cnt <= '0;
            if (done) begin
              state           <= S_IDLE;
              write_end       <= 1'b1;
              arbit_write_end <= 1'b1;
              burst_cnt       <= '0;
            end else if (refresh_req) begin
              state           <= S_REQ;
              arbit_write_end <= 1'b1;
              arbit_write_req <= 1'b1;
            end else begin
              state   <= S_ACT;
              row_end <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
